ula_seq: RTL and testbench

- Multi-cycle command front end for the 32-bit ULA; drives the ULA's a, b and f inputs and consumes its y and zero outputs.
- Accepts MIPS-style commands (opcode, funct, two register operands, 16-bit immediate) over a valid/ready handshake.
- Decodes each command to the 3-bit ULA function code, sequences one ULA evaluation and returns the registered result, zero flag, branch decision and illegal flag over a second valid/ready handshake.
- Sits between the issue logic and the ULA instance; the ULA stays combinational and is instantiated alongside, not inside.

---
 rtl/ula_seq_pkg.sv | 29 ++
 rtl/ula_seq_dec.sv | 58 +++++
 rtl/ula_seq.sv | 126 ++++++++++++
 tb/tb_ula_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_seq_pkg.sv
// Shared encodings for the ULA command sequencer: MIPS opcode/funct values,
// ULA function codes and the small enums used by the decoder and the FSM.
package ula_seq_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] F_AND = 3'b000;
   localparam logic [2:0] F_OR  = 3'b001;
   localparam logic [2:0] F_ADD = 3'b010;
   localparam logic [2:0] F_SUB = 3'b110;
   localparam logic [2:0] F_SLT = 3'b111;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;
   typedef enum logic [1:0] {BR_NONE = 2'd0, BR_EQ = 2'd1, BR_NE = 2'd2} br_e;
   typedef enum logic [1:0] {IMM_NONE = 2'd0, IMM_SEXT = 2'd1, IMM_ZEXT = 2'd2} imm_e;

endpackage

// File: rtl/ula_seq_dec.sv
// Combinational command decoder: opcode/funct to ULA function code, operand B
// source, branch type and illegal flag. Illegal commands decode as a plain AND.
module ula_seq_dec
   import ula_seq_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] f_o,
   output imm_e       imm_mode_o,
   output br_e        br_type_o,
   output logic       illegal_o
);

   always_comb begin
      f_o        = F_AND;
      imm_mode_o = IMM_NONE;
      br_type_o  = BR_NONE;
      illegal_o  = 1'b0;
      case (op_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD:  f_o = F_ADD;
               FN_SUB:  f_o = F_SUB;
               FN_AND:  f_o = F_AND;
               FN_OR:   f_o = F_OR;
               FN_SLT:  f_o = F_SLT;
               default: illegal_o = 1'b1;
            endcase
         end
         OP_ADDI: begin
            f_o        = F_ADD;
            imm_mode_o = IMM_SEXT;
         end
         OP_SLTI: begin
            f_o        = F_SLT;
            imm_mode_o = IMM_SEXT;
         end
         OP_ANDI: begin
            f_o        = F_AND;
            imm_mode_o = IMM_ZEXT;
         end
         OP_ORI: begin
            f_o        = F_OR;
            imm_mode_o = IMM_ZEXT;
         end
         OP_BEQ: begin
            f_o       = F_SUB;
            br_type_o = BR_EQ;
         end
         OP_BNE: begin
            f_o       = F_SUB;
            br_type_o = BR_NE;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/ula_seq.sv
// Multi-cycle front end for the combinational 32-bit ULA: accepts one command,
// drives the ULA for one EXEC cycle, then holds the registered response.
module ula_seq
   import ula_seq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [5:0]        cmd_op,
   input  logic [5:0]        cmd_funct,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [IMM_W-1:0]  cmd_imm,
   output logic [DATA_W-1:0] ula_a,
   output logic [DATA_W-1:0] ula_b,
   output logic [2:0]        ula_f,
   input  logic [DATA_W-1:0] ula_y,
   input  logic              ula_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_y,
   output logic              rsp_zero,
   output logic              rsp_branch,
   output logic              rsp_illegal,
   output logic [CNT_W-1:0]  done_cnt,
   output logic [1:0]        dbg_state_o
);

   state_e              state_q;
   logic [DATA_W-1:0]   ula_a_q, ula_b_q;
   logic [2:0]          ula_f_q;
   br_e                 br_q;
   logic                ill_q;
   logic                rsp_valid_q, rsp_zero_q, rsp_branch_q, rsp_illegal_q;
   logic [DATA_W-1:0]   rsp_y_q;
   logic [CNT_W-1:0]    done_q;

   logic [2:0]          dec_f;
   imm_e                dec_imm;
   br_e                 dec_br;
   logic                dec_illegal;
   logic [DATA_W-1:0]   b_d;

   ula_seq_dec u_dec (
      .op_i       (cmd_op),
      .funct_i    (cmd_funct),
      .f_o        (dec_f),
      .imm_mode_o (dec_imm),
      .br_type_o  (dec_br),
      .illegal_o  (dec_illegal)
   );

   always_comb begin
      case (dec_imm)
         IMM_SEXT: b_d = {{(DATA_W-IMM_W){cmd_imm[IMM_W-1]}}, cmd_imm};
         IMM_ZEXT: b_d = {{(DATA_W-IMM_W){1'b0}}, cmd_imm};
         default:  b_d = cmd_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ula_a_q       <= '0;
         ula_b_q       <= '0;
         ula_f_q       <= F_AND;
         br_q          <= BR_NONE;
         ill_q         <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_y_q       <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_branch_q  <= 1'b0;
         rsp_illegal_q <= 1'b0;
         done_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  ula_a_q <= dec_illegal ? '0 : cmd_a;
                  ula_b_q <= dec_illegal ? '0 : b_d;
                  ula_f_q <= dec_f;
                  br_q    <= dec_br;
                  ill_q   <= dec_illegal;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               // Illegal commands report all-zero results, not the ULA's AND of zeros.
               rsp_valid_q   <= 1'b1;
               rsp_illegal_q <= ill_q;
               rsp_y_q       <= ill_q ? '0 : ula_y;
               rsp_zero_q    <= ill_q ? 1'b0 : ula_zero;
               rsp_branch_q  <= !ill_q && (((br_q == BR_EQ) && ula_zero) ||
                                           ((br_q == BR_NE) && !ula_zero));
               state_q       <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  done_q      <= done_q + CNT_W'(1);
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign ula_a       = ula_a_q;
   assign ula_b       = ula_b_q;
   assign ula_f       = ula_f_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_y       = rsp_y_q;
   assign rsp_zero    = rsp_zero_q;
   assign rsp_branch  = rsp_branch_q;
   assign rsp_illegal = rsp_illegal_q;
   assign done_cnt    = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: directed vector table through the full command/response
// path against a behavioural ULA, plus reset, backpressure and counter-wrap sequences.
module tb_ula_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic [5:0]  cmd_op, cmd_funct;
   logic [31:0] cmd_a, cmd_b;
   logic [15:0] cmd_imm;
   logic        rsp_ready;

   logic        cmd_ready, rsp_valid, rsp_zero, rsp_branch, rsp_illegal;
   logic [31:0] ula_a, ula_b, ula_y, rsp_y;
   logic [2:0]  ula_f;
   logic        ula_zero;
   logic [15:0] done_cnt;
   logic [1:0]  dbg_state;

   // Narrow-counter instance sharing all stimulus, used to observe counter wrap.
   logic        w_cmd_ready, w_rsp_valid, w_rsp_zero, w_rsp_branch, w_rsp_illegal;
   logic [31:0] w_ula_a, w_ula_b, w_ula_y, w_rsp_y;
   logic [2:0]  w_ula_f;
   logic        w_ula_zero;
   logic [2:0]  w_done_cnt;
   logic [1:0]  w_dbg_state;

   int checks = 0;
   int errors = 0;
   int exp_done = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] ula_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f);
      case (f)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   assign ula_y      = ula_model(ula_a, ula_b, ula_f);
   assign ula_zero   = (ula_y == 32'd0);
   assign w_ula_y    = ula_model(w_ula_a, w_ula_b, w_ula_f);
   assign w_ula_zero = (w_ula_y == 32'd0);

   ula_seq #(.DATA_W(32), .IMM_W(16), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_funct(cmd_funct), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_imm(cmd_imm), .ula_a(ula_a), .ula_b(ula_b), .ula_f(ula_f),
      .ula_y(ula_y), .ula_zero(ula_zero), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_zero(rsp_zero),
      .rsp_branch(rsp_branch), .rsp_illegal(rsp_illegal), .done_cnt(done_cnt),
      .dbg_state_o(dbg_state)
   );

   ula_seq #(.DATA_W(32), .IMM_W(16), .CNT_W(3)) dut_wrap (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready),
      .cmd_op(cmd_op), .cmd_funct(cmd_funct), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_imm(cmd_imm), .ula_a(w_ula_a), .ula_b(w_ula_b), .ula_f(w_ula_f),
      .ula_y(w_ula_y), .ula_zero(w_ula_zero), .rsp_valid(w_rsp_valid),
      .rsp_ready(rsp_ready), .rsp_y(w_rsp_y), .rsp_zero(w_rsp_zero),
      .rsp_branch(w_rsp_branch), .rsp_illegal(w_rsp_illegal), .done_cnt(w_done_cnt),
      .dbg_state_o(w_dbg_state)
   );

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] imm;
      logic [31:0] e_ua;
      logic [31:0] e_ub;
      logic [2:0]  e_f;
      logic [31:0] e_y;
      logic        e_z;
      logic        e_br;
      logic        e_il;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive_cmd(input logic [5:0] op, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
      cmd_op = op; cmd_funct = fn; cmd_a = a; cmd_b = b; cmd_imm = imm;
      cmd_valid = 1'b1;
   endtask

   task automatic scramble_cmd();
      cmd_op    = 6'($urandom_range(0, 63));
      cmd_funct = 6'($urandom_range(0, 63));
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      cmd_imm   = 16'($urandom_range(0, 65535));
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
   task automatic run_vec(input int i, input vec_t v);
      drive_cmd(v.op, v.funct, v.a, v.b, v.imm);
      chk($sformatf("v%0d_cmd_ready_idle", i), 32'(cmd_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      scramble_cmd();
      chk($sformatf("v%0d_state_exec", i), 32'(dbg_state), 32'd1);
      chk($sformatf("v%0d_cmd_ready_exec", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("v%0d_rsp_valid_exec", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d_ula_a", i), ula_a, v.e_ua);
      chk($sformatf("v%0d_ula_b", i), ula_b, v.e_ub);
      chk($sformatf("v%0d_ula_f", i), 32'(ula_f), 32'(v.e_f));
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_cmd_ready_resp", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("v%0d_rsp_y", i), rsp_y, v.e_y);
      chk($sformatf("v%0d_rsp_zero", i), 32'(rsp_zero), 32'(v.e_z));
      chk($sformatf("v%0d_rsp_branch", i), 32'(rsp_branch), 32'(v.e_br));
      chk($sformatf("v%0d_rsp_illegal", i), 32'(rsp_illegal), 32'(v.e_il));
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      exp_done++;
      chk($sformatf("v%0d_rsp_valid_drop", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d_cmd_ready_back", i), 32'(cmd_ready), 32'd1);
      chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'(exp_done));
      chk($sformatf("v%0d_wrap_done_cnt", i), 32'(w_done_cnt), 32'(exp_done % 8));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ula_a"}, ula_a, 32'd0);
      chk({tag, "_ula_b"}, ula_b, 32'd0);
      chk({tag, "_ula_f"}, 32'(ula_f), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_y"}, rsp_y, 32'd0);
      chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
      chk({tag, "_rsp_branch"}, 32'(rsp_branch), 32'd0);
      chk({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
   endtask

   initial begin
      //            op     funct  a             b             imm       ula_a         ula_b         f     y             z     br    il
      vecs[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        16'h0000, 32'd5,        32'd7,        3'b010, 32'd12,       1'b0, 1'b0, 1'b0};
      vecs[1]  = '{6'h00, 6'h22, 32'd5,        32'd7,        16'h0000, 32'd5,        32'd7,        3'b110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{6'h00, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0000, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{6'h00, 6'h25, 32'h12000000, 32'h00000034, 16'h0000, 32'h12000000, 32'h00000034, 3'b001, 32'h12000034, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        16'h0000, 32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b0, 1'b0, 1'b0};
      vecs[5]  = '{6'h00, 6'h2A, 32'd1,        32'hFFFFFFFF, 16'h0000, 32'd1,        32'hFFFFFFFF, 3'b111, 32'd0,        1'b1, 1'b0, 1'b0};
      vecs[6]  = '{6'h08, 6'h00, 32'd3,        32'hDEADBEEF, 16'hFFFD, 32'd3,        32'hFFFFFFFD, 3'b010, 32'd0,        1'b1, 1'b0, 1'b0};
      vecs[7]  = '{6'h0A, 6'h2A, 32'd5,        32'hDEADBEEF, 16'h0006, 32'd5,        32'd6,        3'b111, 32'd1,        1'b0, 1'b0, 1'b0};
      vecs[8]  = '{6'h0C, 6'h00, 32'hFFFF1234, 32'h00000000, 16'h8F0F, 32'hFFFF1234, 32'h00008F0F, 3'b000, 32'h00000204, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{6'h0D, 6'h00, 32'd0,        32'h55555555, 16'h8000, 32'd0,        32'h00008000, 3'b001, 32'h00008000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{6'h04, 6'h00, 32'h1234,     32'h1234,     16'hFFFF, 32'h1234,     32'h1234,     3'b110, 32'd0,        1'b1, 1'b1, 1'b0};
      vecs[11] = '{6'h05, 6'h00, 32'h1234,     32'h1234,     16'hFFFF, 32'h1234,     32'h1234,     3'b110, 32'd0,        1'b1, 1'b0, 1'b0};
      vecs[12] = '{6'h04, 6'h00, 32'd1,        32'd2,        16'h0000, 32'd1,        32'd2,        3'b110, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{6'h05, 6'h00, 32'd1,        32'd2,        16'h0000, 32'd1,        32'd2,        3'b110, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{6'h3F, 6'h20, 32'd5,        32'd7,        16'h1234, 32'd0,        32'd0,        3'b000, 32'd0,        1'b0, 1'b0, 1'b1};
      vecs[15] = '{6'h00, 6'h00, 32'd5,        32'd7,        16'h1234, 32'd0,        32'd0,        3'b000, 32'd0,        1'b0, 1'b0, 1'b1};

      reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = '0; cmd_funct = '0; cmd_a = '0; cmd_b = '0; cmd_imm = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_state("por");
      reset = 1'b0;

      // Reset while in EXEC with a command still offered.
      @(negedge clk);
      drive_cmd(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
      @(posedge clk); @(negedge clk);
      chk("rst_exec_pre_state", 32'(dbg_state), 32'd1);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      chk_reset_state("rst_exec");
      reset = 1'b0; cmd_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         chk("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Reset while in RESP with a command still offered.
      drive_cmd(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("rst_resp_pre_valid", 32'(rsp_valid), 32'd1);
      chk("rst_resp_pre_y", rsp_y, 32'd12);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      chk_reset_state("rst_resp");
      reset = 1'b0; cmd_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         chk("rst_resp_no_rsp", 32'(rsp_valid), 32'd0);
         chk("rst_resp_done", 32'(done_cnt), 32'd0);
      end

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      // Backpressure: response held for 5 cycles while another command is offered.
      drive_cmd(6'h00, 6'h22, 32'd10, 32'd3, 16'h0);
      @(posedge clk); @(negedge clk);
      drive_cmd(6'h00, 6'h20, 32'd100, 32'd200, 16'h0);
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp%0d_rsp_y", k), rsp_y, 32'd7);
         chk($sformatf("bp%0d_rsp_zero", k), 32'(rsp_zero), 32'd0);
         chk($sformatf("bp%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
         chk($sformatf("bp%0d_ula_a", k), ula_a, 32'd10);
         chk($sformatf("bp%0d_done", k), 32'(done_cnt), 32'(exp_done));
         @(posedge clk); @(negedge clk);
      end
      rsp_ready = 1'b1; cmd_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      exp_done++;
      chk("bp_rsp_valid_drop", 32'(rsp_valid), 32'd0);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("bp_done_cnt", 32'(done_cnt), 32'(exp_done));
      chk("bp_wrap_done_cnt", 32'(w_done_cnt), 32'(exp_done % 8));

      // rsp_ready pulsed while idle must not count.
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_ready_done_cnt", 32'(done_cnt), 32'(exp_done));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
